// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: byte width and feeder FSM encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal arriving from another clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus level-handshake sequencer feeding a UART transmitter on a slower txClk.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   idle
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wrPtr;
    logic [ADDR_W-1:0]      rdPtr;
    logic [1:0]             state;
    logic                   busyS;
    logic                   doneS;
    logic                   push;
    logic                   pop;
    logic [ADDR_W:0]        countNext;

    sync_2ff uBusySync (.clk(clk), .rst(rst), .d(tx_busy), .q(busyS));
    sync_2ff uDoneSync (.clk(clk), .rst(rst), .d(tx_done), .q(doneS));

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push = wr_en && !full;
    assign pop  = (state == ST_IDLE) && !empty;
    assign idle = (state == ST_IDLE) && empty;

    always_comb begin
        countNext = count;
        if (push && !pop) begin
            countNext = count + ONE_CNT;
        end else if (pop && !push) begin
            countNext = count - ONE_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            count    <= countNext;
            full     <= (countNext == FULL_CNT);
            empty    <= (countNext == '0);
            overflow <= wr_en && full;
        end
    end

    // tx_start stays high until the transmitter is seen busy, so a slow txClk cannot miss it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        tx_data  <= mem[rdPtr];
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (busyS) begin
                        state <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    tx_start <= 1'b0;
                    state    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!busyS || doneS) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
